// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller for load-use, taken branch, multi-cycle divide and halt.
// Optional macro PIPE_STALL_COUNTER_EN adds a saturating 16-bit stall_cnt output.
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_wn,
    input  logic       id_div_start,
    input  logic       branch_taken,
    input  logic       halt_req,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       div_busy,
    output logic       div_done,
    output logic [1:0] state
`ifdef PIPE_STALL_COUNTER_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DIVBUSY = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t     cur_state, nxt_state;
    logic [5:0] cnt, cnt_nxt;
    logic       halt_pend, halt_pend_nxt;
    logic       load_use;

    assign load_use = ex_memread && (ex_wn != 5'd0) &&
                      ((ex_wn == id_rs) || (ex_wn == id_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= RUN;
            cnt       <= 6'd0;
            halt_pend <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
            halt_pend <= halt_pend_nxt;
        end
    end

    always_comb begin
        nxt_state     = cur_state;
        cnt_nxt       = cnt;
        halt_pend_nxt = halt_pend;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        div_busy      = 1'b0;
        div_done      = 1'b0;

        case (cur_state)
            RUN: begin
                // A taken branch squashes ID, so any load-use or divide in ID is moot.
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
                if (halt_req) begin
                    nxt_state = HALT;
                end else if (id_div_start && !load_use && !branch_taken) begin
                    nxt_state = DIVBUSY;
                    cnt_nxt   = 6'(DIV_CYCLES - 1);
                end
            end
            DIVBUSY: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                div_busy = 1'b1;
                if (cnt == 6'd0) begin
                    // Last cycle: the divide result advances out of EX.
                    div_done      = 1'b1;
                    idex_en       = 1'b1;
                    halt_pend_nxt = 1'b0;
                    nxt_state     = (halt_pend || halt_req) ? HALT : RUN;
                end else begin
                    exmem_flush = 1'b1;
                    cnt_nxt     = cnt - 6'd1;
                    if (halt_req) begin
                        halt_pend_nxt = 1'b1;
                    end
                end
            end
            HALT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            default: begin
                nxt_state = RUN;
            end
        endcase

        // Stage controls show RUN-idle values for the whole reset pulse.
        if (rst) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
        end
    end

    assign state = cur_state;

`ifdef PIPE_STALL_COUNTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (!pc_en && (cur_state != HALT) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning the number of cycles a divide occupies EX (legal 2..63).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high; clk and rst are the only clock/reset.
REQ-004 SHALL have ports id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports ex_memread  in  1, and ex_wn  in  5  load flag and destination register of the instruction in EX.
REQ-006 SHALL have port id_div_start  in  1  instruction in ID is a divide.
REQ-007 SHALL have port branch_taken  in  1  branch resolved taken in EX.
REQ-008 SHALL have port halt_req  in  1  halt instruction reached WB.
REQ-009 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  per-stage register enables (drive en_reg of the pipeline registers).
REQ-010 SHALL have ports ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble into that stage register this cycle.
REQ-011 SHALL have ports div_busy  out  1, div_done  out  1, and state  out  2  (RUN=0, DIVBUSY=2, HALT=3; 1 unused).

Function
REQ-012 In RUN with no event, all enables SHALL be 1 and all flushes 0.
REQ-013 load_use SHALL be ex_memread AND ex_wn!=0 AND (ex_wn==id_rs OR ex_wn==id_rt), evaluated combinationally.
REQ-014 In RUN, load_use without branch_taken SHALL give pc_en=0, ifid_en=0, idex_flush=1, other enables 1, same cycle; no state change.
REQ-015 In RUN, branch_taken SHALL give ifid_flush=1, idex_flush=1, pc_en=1, and SHALL override load_use and id_div_start.
REQ-016 In RUN, id_div_start without load_use or branch_taken SHALL move to DIVBUSY at next edge and load a 6-bit counter with DIV_CYCLES-1.
REQ-017 In DIVBUSY: pc_en=ifid_en=idex_en=0, exmem_en=memwb_en=1, exmem_flush=1, div_busy=1; counter decrements each cycle.
REQ-018 In DIVBUSY with counter==0: div_done=1 for that single cycle, exmem_flush=0, idex_en=1, and the FSM SHALL return to RUN next edge; total DIVBUSY residency = DIV_CYCLES cycles.
REQ-019 In RUN, halt_req SHALL move to HALT at next edge, overriding all other requests.
REQ-020 In DIVBUSY, halt_req SHALL set a pending flag; on exit the FSM SHALL go to HALT instead of RUN; flag clears on entering HALT.
REQ-021 In HALT all enables and flushes SHALL be 0; only rst leaves HALT.
REQ-022 branch_taken and load_use SHALL be ignored outside RUN.

Reset
REQ-023 rst SHALL asynchronously force state=RUN, counter=0, halt pending=0, div_busy=0, div_done=0.
REQ-024 Enable and flush outputs SHALL read their RUN-idle values (enables 1, flushes 0) while rst is high.
REQ-025 rst asserted mid-divide SHALL abort it with no div_done pulse.

Configuration
REQ-026 Macro PIPE_STALL_COUNTER_EN defined: adds output stall_cnt, 16 bits, counting cycles with pc_en=0 outside HALT, saturating at 0xFFFF, cleared by rst.
REQ-027 Macro undefined: no stall_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-028 ex_memread=1, ex_wn=5, id_rt=5 in RUN -> same cycle pc_en=0, ifid_en=0, idex_flush=1; ex_wn=0 case -> no stall.
REQ-029 load_use and branch_taken together -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-030 id_div_start with DIV_CYCLES=32 -> div_busy high exactly 32 cycles, div_done single pulse in the 32nd, RUN afterwards.
REQ-031 halt_req at DIVBUSY cycle 10 -> divide completes (div_done pulses), then state=3 with all enables 0.
REQ-032 rst pulsed at DIVBUSY cycle 5 between edges -> state=0 immediately, no div_done; with PIPE_STALL_COUNTER_EN, stall_cnt=0 after reset and equals 32 after one full divide.
